// File: rtl/cic_dec_ctrl.sv
// Run-time sequencer for a programmable CIC decimator: gates samples in, applies factor changes via
// a flush/settle sequence that discards transient outputs, and buffers results behind valid/ready.
module cic_dec_ctrl #(
    parameter int unsigned SECTIONS       = 3,
    parameter int unsigned FACTOR_W       = 16,
    parameter int unsigned DEFAULT_FACTOR = 5,
    parameter int unsigned IN_W           = 12,
    parameter int unsigned OUT_W          = 18,
    parameter int unsigned FLUSH_CYCLES   = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic [FACTOR_W-1:0] cfg_factor,
    input  logic                cfg_load,
    input  logic                in_valid,
    input  logic [IN_W-1:0]     in_data,
    output logic                cic_ce,
    output logic [IN_W-1:0]     cic_din,
    output logic                cic_rst,
    output logic [FACTOR_W-1:0] cic_factor,
    input  logic                cic_ce_out,
    input  logic [OUT_W-1:0]    cic_dout,
    output logic                out_valid,
    output logic [OUT_W-1:0]    out_data,
    input  logic                out_ready,
    output logic                busy,
    output logic                cfg_err,
    output logic                overrun
);

    localparam int unsigned FlushW  = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES + 1) : 1;
    localparam int unsigned SettleW = (SECTIONS > 1) ? $clog2(SECTIONS + 1) : 1;

    typedef enum logic [1:0] {StIdle, StFlush, StSettle, StRun} state_t;

    state_t              state;
    logic [FACTOR_W-1:0] factor_active;
    logic [FACTOR_W-1:0] pending;
    logic                pend_flag;
    logic [FlushW-1:0]   flush_cnt;
    logic [SettleW-1:0]  settle_cnt;
    logic                load_ok;

    assign load_ok    = cfg_load && (cfg_factor != '0);
    assign cic_factor = factor_active;
    assign busy       = (state == StFlush) || (state == StSettle);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= StIdle;
            factor_active <= FACTOR_W'(DEFAULT_FACTOR);
            pending       <= FACTOR_W'(DEFAULT_FACTOR);
            pend_flag     <= 1'b0;
            flush_cnt     <= '0;
            settle_cnt    <= '0;
            cic_ce        <= 1'b0;
            cic_din       <= '0;
            cic_rst       <= 1'b0;
            out_valid     <= 1'b0;
            out_data      <= '0;
            cfg_err       <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            cfg_err <= cfg_load && (cfg_factor == '0);
            if (load_ok) begin
                pending   <= cfg_factor;
                pend_flag <= 1'b1;
            end
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            if (!enable) begin
                state     <= StIdle;
                cic_rst   <= 1'b0;
                cic_ce    <= 1'b0;
                out_valid <= 1'b0;
                overrun   <= 1'b0;
            end else begin
                unique case (state)
                    StIdle: begin
                        state         <= StFlush;
                        cic_rst       <= 1'b1;
                        cic_ce        <= 1'b0;
                        flush_cnt     <= '0;
                        factor_active <= pending;
                        pend_flag     <= load_ok;
                        out_valid     <= 1'b0;
                        overrun       <= 1'b0;
                    end
                    StFlush: begin
                        cic_ce <= 1'b0;
                        if (flush_cnt == FlushW'(FLUSH_CYCLES - 1)) begin
                            state      <= StSettle;
                            cic_rst    <= 1'b0;
                            settle_cnt <= '0;
                        end else begin
                            flush_cnt <= flush_cnt + 1'b1;
                        end
                    end
                    StSettle: begin
                        cic_ce  <= in_valid;
                        cic_din <= in_data;
                        // Transient outputs are counted and discarded, never buffered.
                        if (cic_ce_out) begin
                            if (settle_cnt == SettleW'(SECTIONS - 1)) begin
                                state <= StRun;
                            end else begin
                                settle_cnt <= settle_cnt + 1'b1;
                            end
                        end
                    end
                    StRun: begin
                        cic_ce  <= in_valid;
                        cic_din <= in_data;
                        if (cic_ce_out) begin
                            if (!out_valid || out_ready) begin
                                out_data  <= cic_dout;
                                out_valid <= 1'b1;
                            end else begin
                                overrun <= 1'b1;
                            end
                        end
                        // Buffered sample stays offered across the re-flush.
                        if (pend_flag) begin
                            state         <= StFlush;
                            cic_rst       <= 1'b1;
                            cic_ce        <= 1'b0;
                            flush_cnt     <= '0;
                            factor_active <= pending;
                            pend_flag     <= load_ok;
                        end
                    end
                    default: state <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cic_dec_ctrl.sv
// Directed bench for cic_dec_ctrl: flush/settle sequencing, output buffering, overrun,
// factor reconfiguration, cfg_err, enable drop and asynchronous reset.
module tb_cic_dec_ctrl;

    logic        clk;
    logic        reset;
    logic        enable;
    logic [15:0] cfg_factor;
    logic        cfg_load;
    logic        in_valid;
    logic [11:0] in_data;
    logic        cic_ce;
    logic [11:0] cic_din;
    logic        cic_rst;
    logic [15:0] cic_factor;
    logic        cic_ce_out;
    logic [17:0] cic_dout;
    logic        out_valid;
    logic [17:0] out_data;
    logic        out_ready;
    logic        busy;
    logic        cfg_err;
    logic        overrun;

    int checks   = 0;
    int failures = 0;

    cic_dec_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .cfg_factor (cfg_factor),
        .cfg_load   (cfg_load),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .cic_ce     (cic_ce),
        .cic_din    (cic_din),
        .cic_rst    (cic_rst),
        .cic_factor (cic_factor),
        .cic_ce_out (cic_ce_out),
        .cic_dout   (cic_dout),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .busy       (busy),
        .cfg_err    (cfg_err),
        .overrun    (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse(input logic [17:0] d);
        cic_ce_out = 1'b1;
        cic_dout   = d;
        step();
        cic_ce_out = 1'b0;
    endtask

    // enable from IDLE, wait out the flush and the three discarded outputs
    task automatic bring_up(input logic [15:0] exp_factor);
        enable = 1'b1;
        step();
        check("bring_factor", 32'(cic_factor), 32'(exp_factor));
        repeat (4) step();
        check("bring_settle_busy", 32'(busy), 1);
        pulse(18'h00aa);
        pulse(18'h00bb);
        pulse(18'h00cc);
        check("bring_run_busy", 32'(busy), 0);
        check("bring_no_valid", 32'(out_valid), 0);
    endtask

    initial begin
        reset      = 1'b1;
        enable     = 1'b0;
        cfg_factor = '0;
        cfg_load   = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        cic_ce_out = 1'b0;
        cic_dout   = '0;
        out_ready  = 1'b0;
        repeat (2) step();

        check("rst_cic_rst", 32'(cic_rst), 0);
        check("rst_cic_ce", 32'(cic_ce), 0);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_factor", 32'(cic_factor), 5);
        check("rst_overrun", 32'(overrun), 0);
        check("rst_cfg_err", 32'(cfg_err), 0);

        // Start-up: flush for four cycles, ignoring in_valid
        reset    = 1'b0;
        in_valid = 1'b1;
        enable   = 1'b1;
        step();
        for (int i = 0; i < 4; i++) begin
            check("flush_rst_high", 32'(cic_rst), 1);
            check("flush_ce_low", 32'(cic_ce), 0);
            check("flush_busy", 32'(busy), 1);
            step();
        end
        check("settle_rst_low", 32'(cic_rst), 0);
        check("settle_busy", 32'(busy), 1);
        in_data = 12'h5a3;
        step();
        check("settle_ce", 32'(cic_ce), 1);
        check("settle_din", 32'(cic_din), 32'h5a3);
        in_data = 12'ha5c;
        step();
        check("settle_din2", 32'(cic_din), 32'ha5c);

        pulse(18'h00011);
        check("drop1_valid", 32'(out_valid), 0);
        check("drop1_busy", 32'(busy), 1);
        pulse(18'h00022);
        check("drop2_valid", 32'(out_valid), 0);
        pulse(18'h00033);
        check("drop3_valid", 32'(out_valid), 0);
        check("drop3_busy", 32'(busy), 0);
        pulse(18'h2abcd);
        check("first_valid", 32'(out_valid), 1);
        check("first_data", 32'(out_data), 32'h2abcd);
        out_ready = 1'b1;
        step();
        check("first_accepted", 32'(out_valid), 0);

        // Ramp every 5th cycle with downstream always ready
        for (int k = 0; k < 4; k++) begin
            pulse(18'h00100 + 18'(k));
            check("ramp_valid", 32'(out_valid), 1);
            check("ramp_data", 32'(out_data), 32'h100 + 32'(k));
            step();
            check("ramp_accepted", 32'(out_valid), 0);
            repeat (3) step();
        end

        // Backpressure: second sample dropped, overrun sticky
        out_ready = 1'b0;
        pulse(18'h01234);
        check("bp_valid", 32'(out_valid), 1);
        check("bp_data", 32'(out_data), 32'h1234);
        check("bp_no_overrun", 32'(overrun), 0);
        repeat (2) step();
        pulse(18'h05678);
        check("bp_held_data", 32'(out_data), 32'h1234);
        check("bp_overrun", 32'(overrun), 1);
        step();
        check("bp_overrun_sticky", 32'(overrun), 1);
        out_ready = 1'b1;
        step();
        check("bp_drained", 32'(out_valid), 0);
        check("bp_overrun_after_accept", 32'(overrun), 1);
        enable = 1'b0;
        step();
        check("dis_overrun_clr", 32'(overrun), 0);
        check("dis_busy", 32'(busy), 0);
        check("dis_ce", 32'(cic_ce), 0);

        bring_up(16'd5);

        // Reconfigure to 8 with a sample still buffered
        out_ready = 1'b0;
        pulse(18'h00abc);
        check("recfg_valid", 32'(out_valid), 1);
        cfg_factor = 16'd8;
        cfg_load   = 1'b1;
        step();
        cfg_load = 1'b0;
        check("recfg_still_run", 32'(busy), 0);
        check("recfg_factor_old", 32'(cic_factor), 5);
        step();
        check("recfg_flush_rst", 32'(cic_rst), 1);
        check("recfg_factor_new", 32'(cic_factor), 8);
        check("recfg_busy", 32'(busy), 1);
        check("recfg_buf_valid", 32'(out_valid), 1);
        check("recfg_buf_data", 32'(out_data), 32'habc);
        out_ready = 1'b1;
        step();
        check("recfg_buf_accepted", 32'(out_valid), 0);
        check("recfg_rst_hold", 32'(cic_rst), 1);
        repeat (3) step();
        check("recfg_settle_rst", 32'(cic_rst), 0);
        check("recfg_settle_busy", 32'(busy), 1);
        pulse(18'h00001);
        pulse(18'h00002);
        check("recfg_busy_2drops", 32'(busy), 1);
        pulse(18'h00003);
        check("recfg_run", 32'(busy), 0);
        check("recfg_drops_hidden", 32'(out_valid), 0);

        // Zero factor request is rejected
        cfg_factor = 16'd0;
        cfg_load   = 1'b1;
        step();
        cfg_load = 1'b0;
        check("zero_cfg_err", 32'(cfg_err), 1);
        check("zero_factor", 32'(cic_factor), 8);
        check("zero_busy", 32'(busy), 0);
        step();
        check("zero_cfg_err_pulse", 32'(cfg_err), 0);
        check("zero_no_flush", 32'(cic_rst), 0);
        step();
        check("zero_still_run", 32'(busy), 0);

        // Drop enable mid-SETTLE; pending load retained for the next flush
        enable = 1'b0;
        step();
        enable = 1'b1;
        step();
        check("s_flush_factor", 32'(cic_factor), 8);
        repeat (4) step();
        check("s_settle_busy", 32'(busy), 1);
        cfg_factor = 16'd6;
        cfg_load   = 1'b1;
        step();
        cfg_load = 1'b0;
        check("s_load_deferred", 32'(cic_factor), 8);
        check("s_still_settle", 32'(busy), 1);
        enable = 1'b0;
        step();
        check("s_dis_busy", 32'(busy), 0);
        check("s_dis_ce", 32'(cic_ce), 0);
        check("s_dis_valid", 32'(out_valid), 0);
        check("s_dis_factor", 32'(cic_factor), 8);
        enable = 1'b0;
        bring_up(16'd6);

        // Asynchronous reset mid-RUN with a sample buffered
        out_ready = 1'b0;
        pulse(18'h00777);
        check("ar_valid_before", 32'(out_valid), 1);
        #2;
        reset = 1'b1;
        #1;
        check("ar_valid", 32'(out_valid), 0);
        check("ar_ce", 32'(cic_ce), 0);
        check("ar_busy", 32'(busy), 0);
        check("ar_rst", 32'(cic_rst), 0);
        check("ar_factor", 32'(cic_factor), 5);
        enable = 1'b0;
        step();
        reset = 1'b0;
        step();
        check("ar_idle_busy", 32'(busy), 0);
        check("ar_idle_rst", 32'(cic_rst), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
